// File: rtl/qsn_pkg.sv
// qsn_pkg: shared constants, schedule entry and FSM state types
// for the quasi-cyclic shift network sequencer.
package qsn_pkg;

  localparam int LiftingFactor = 4;
  localparam int ShiftWidth    = $clog2(LiftingFactor);
  localparam int NumEntries    = 8;
  localparam int IdxWidth      = $clog2(NumEntries);

  typedef struct packed {
    logic                  en;
    logic [ShiftWidth-1:0] shift;
  } entry_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/qsn_rotator.sv
// qsn_rotator: combinational Z-bit cyclic rotator.
// Ports: i_data/i_shift in, o_data[i] = i_data[(i+shift) mod Z].
module qsn_rotator
  import qsn_pkg::*;
(
  input  logic [LiftingFactor-1:0] i_data,
  input  logic [ShiftWidth-1:0]    i_shift,
  output logic [LiftingFactor-1:0] o_data
);

  logic [2*LiftingFactor-1:0] w_dbl;

  // Window into the doubled word gives the wrap without a modulo.
  assign w_dbl  = {i_data, i_data};
  assign o_data = w_dbl[{1'b0, i_shift} +: LiftingFactor];

endmodule

// File: rtl/qsn_sequencer.sv
// qsn_sequencer: walks a programmable shift schedule, rotating input
// blocks (or emitting zero for null entries) into a registered stream.
module qsn_sequencer
  import qsn_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [IdxWidth-1:0]        cfg_addr,
  input  logic [ShiftWidth:0]        cfg_wdata,
  input  logic                       start,
  input  logic [IdxWidth-1:0]        len_m1,
  input  logic                       abort,
  input  logic [LiftingFactor-1:0]   in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [LiftingFactor-1:0]   out_data,
  output logic [IdxWidth-1:0]        out_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  state_t                     r_state;
  state_t                     w_state_nxt;
  entry_t                     r_tab [NumEntries];
  logic [IdxWidth-1:0]        r_idx;
  logic [IdxWidth-1:0]        r_last;
  logic [LiftingFactor-1:0]   r_out_data;
  logic [IdxWidth-1:0]        r_out_idx;
  logic                       r_out_valid;
  logic                       r_done;

  entry_t                     w_cur;
  logic [LiftingFactor-1:0]   w_rot;
  logic                       w_slot_free;
  logic                       w_last_hit;
  logic                       w_in_ready;
  logic                       w_issue;

  assign w_cur       = r_tab[r_idx];
  assign w_slot_free = ~r_out_valid | out_ready;
  assign w_last_hit  = (r_idx == r_last);

  qsn_rotator u_rot (
    .i_data  (in_data),
    .i_shift (w_cur.shift),
    .o_data  (w_rot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Abort also masks in_ready so no block is swallowed on the abort edge.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_issue     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_in_ready = w_cur.en & w_slot_free & ~abort;
        w_issue    = w_cur.en ? (in_valid & w_in_ready)
                              : (w_slot_free & ~abort);
        if (w_issue && w_last_hit) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumEntries; i++) r_tab[i] <= '0;
      r_idx       <= '0;
      r_last      <= '0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (cfg_we && r_state == S_IDLE)
        r_tab[cfg_addr] <= entry_t'(cfg_wdata);
      if (abort) begin
        r_out_valid <= 1'b0;
        r_idx       <= '0;
      end else begin
        if (r_state == S_IDLE && start) begin
          r_idx  <= '0;
          r_last <= len_m1;
        end
        if (w_issue) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_cur.en ? w_rot : '0;
          r_out_idx   <= r_idx;
          if (w_last_hit) r_done <= 1'b1;
          else            r_idx  <= r_idx + 1'b1;
        end else if (out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_valid = r_out_valid;
  assign busy      = (r_state == S_RUN);
  assign done      = r_done;

endmodule
